// File: rtl/oldest2_req_ring_pkg.sv
// Shared definitions for the oldest-2 request ring: default geometry and the
// per-entry state record.
package oldest2_req_ring_pkg;

    localparam int SEL_WIDTH_DEF      = 8;
    localparam int PRIORITY_WIDTH_DEF = 3;

    typedef struct packed {
        logic valid;
        logic ready;
        logic ls;
        logic issued;
    } entry_t;

endpackage

// File: rtl/ring_ptr_ctrl.sv
// Head/tail/count bookkeeping for the request ring: decides how many entries
// are allocated and retired each cycle and advances the pointers with wrap.
module ring_ptr_ctrl
    import oldest2_req_ring_pkg::*;
#(
    parameter int SEL_WIDTH      = SEL_WIDTH_DEF,
    parameter int PRIORITY_WIDTH = PRIORITY_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alloc_first_valid,
    input  logic                      alloc_second_valid,
    input  logic                      head_done,
    input  logic                      next_done,
    output logic [PRIORITY_WIDTH-1:0] head,
    output logic [PRIORITY_WIDTH-1:0] tail,
    output logic [PRIORITY_WIDTH:0]   count,
    output logic                      alloc_ready,
    output logic                      alloc_first_en,
    output logic                      alloc_second_en,
    output logic                      retire_first,
    output logic                      retire_second
);

    logic [PRIORITY_WIDTH:0] alloc_cnt;
    logic [PRIORITY_WIDTH:0] retire_cnt;

    // Retire only walks over occupied slots, so the count bounds it and it
    // can never run past the tail.
    always_comb begin
        alloc_ready     = count <= (PRIORITY_WIDTH+1)'(SEL_WIDTH - 2);
        alloc_first_en  = alloc_first_valid & alloc_ready;
        alloc_second_en = alloc_second_valid & alloc_first_en;
        retire_first    = (count != '0) & head_done;
        retire_second   = retire_first & (count >= (PRIORITY_WIDTH+1)'(2)) & next_done;
        alloc_cnt       = (PRIORITY_WIDTH+1)'(alloc_first_en) + (PRIORITY_WIDTH+1)'(alloc_second_en);
        retire_cnt      = (PRIORITY_WIDTH+1)'(retire_first) + (PRIORITY_WIDTH+1)'(retire_second);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + retire_cnt[PRIORITY_WIDTH-1:0];
            tail  <= tail + alloc_cnt[PRIORITY_WIDTH-1:0];
            count <= count + alloc_cnt - retire_cnt;
        end
    end

endmodule

// File: rtl/oldest2_req_ring.sv
// Age-ordered entry ring feeding the oldest-2 issue arbiter: holds per-entry
// ready/ls/issued state and turns it into registered request vectors.
module oldest2_req_ring
    import oldest2_req_ring_pkg::*;
#(
    parameter int SEL_WIDTH      = SEL_WIDTH_DEF,
    parameter int PRIORITY_WIDTH = PRIORITY_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      alloc_first_valid_i,
    input  logic                      alloc_second_valid_i,
    input  logic                      alloc_first_ready_i,
    input  logic                      alloc_second_ready_i,
    input  logic                      alloc_first_ls_i,
    input  logic                      alloc_second_ls_i,
    output logic                      alloc_ready_o,
    output logic [PRIORITY_WIDTH-1:0] alloc_first_index_o,
    output logic [PRIORITY_WIDTH-1:0] alloc_second_index_o,
    input  logic [SEL_WIDTH-1:0]      wakeup_i,
    input  logic                      first_grant_valid_i,
    input  logic [PRIORITY_WIDTH-1:0] first_grant_index_i,
    input  logic                      second_grant_valid_i,
    input  logic [PRIORITY_WIDTH-1:0] second_grant_index_i,
    output logic [SEL_WIDTH-1:0]      req_o,
    output logic [SEL_WIDTH-1:0]      req_ls_o,
    output logic [PRIORITY_WIDTH-1:0] priority_fix_o,
    output logic [PRIORITY_WIDTH:0]   count_o,
    output logic                      empty_o
);

    entry_t ent      [SEL_WIDTH];
    entry_t ent_next [SEL_WIDTH];

    logic [PRIORITY_WIDTH-1:0] head, tail, head_p1, tail_p1;
    logic alloc_first_en, alloc_second_en, retire_first, retire_second;
    logic head_done, next_done, first_grant_ok, second_grant_ok;

    assign head_p1   = head + PRIORITY_WIDTH'(1);
    assign tail_p1   = tail + PRIORITY_WIDTH'(1);
    assign head_done = ent[head].valid & ent[head].issued;
    assign next_done = ent[head_p1].valid & ent[head_p1].issued;

    ring_ptr_ctrl #(
        .SEL_WIDTH      (SEL_WIDTH),
        .PRIORITY_WIDTH (PRIORITY_WIDTH)
    ) u_ptr (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush_i),
        .alloc_first_valid  (alloc_first_valid_i),
        .alloc_second_valid (alloc_second_valid_i),
        .head_done          (head_done),
        .next_done          (next_done),
        .head               (head),
        .tail               (tail),
        .count              (count_o),
        .alloc_ready        (alloc_ready_o),
        .alloc_first_en     (alloc_first_en),
        .alloc_second_en    (alloc_second_en),
        .retire_first       (retire_first),
        .retire_second      (retire_second)
    );

    // Allocation slots are always free and retiring slots always issued, so
    // the alloc, grant and retire updates never touch the same entry.
    always_comb begin
        ent_next        = ent;
        first_grant_ok  = ent[first_grant_index_i].valid & ~ent[first_grant_index_i].issued;
        second_grant_ok = ent[second_grant_index_i].valid & ~ent[second_grant_index_i].issued;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            if (ent[i].valid && wakeup_i[i])
                ent_next[i].ready = 1'b1;
        end
        if (first_grant_valid_i && first_grant_ok)
            ent_next[first_grant_index_i].issued = 1'b1;
        if (second_grant_valid_i && second_grant_ok)
            ent_next[second_grant_index_i].issued = 1'b1;
        if (retire_first)
            ent_next[head] = '0;
        if (retire_second)
            ent_next[head_p1] = '0;
        if (alloc_first_en)
            ent_next[tail] = '{valid: 1'b1, ready: alloc_first_ready_i | wakeup_i[tail],
                               ls: alloc_first_ls_i, issued: 1'b0};
        if (alloc_second_en)
            ent_next[tail_p1] = '{valid: 1'b1, ready: alloc_second_ready_i | wakeup_i[tail_p1],
                                  ls: alloc_second_ls_i, issued: 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SEL_WIDTH; i++) ent[i] <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < SEL_WIDTH; i++) ent[i] <= '0;
        end else begin
            ent <= ent_next;
        end
    end

    always_comb begin
        req_o    = '0;
        req_ls_o = '0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            req_o[i]    = ent[i].valid & ent[i].ready & ~ent[i].issued;
            req_ls_o[i] = ent[i].valid & ent[i].ls & ~ent[i].issued;
        end
    end

    assign priority_fix_o       = head;
    assign alloc_first_index_o  = tail;
    assign alloc_second_index_o = tail_p1;
    assign empty_o              = (count_o == '0);

    // The arbiter must only grant live, not-yet-issued entries.
    grant_first_legal: assert property (@(posedge clk) disable iff (rst)
        (first_grant_valid_i && !flush_i) |-> first_grant_ok);
    grant_second_legal: assert property (@(posedge clk) disable iff (rst)
        (second_grant_valid_i && !flush_i) |-> second_grant_ok);

endmodule

// File: tb/tb_oldest2_req_ring.sv
// Self-checking bench for oldest2_req_ring: directed vector table followed by
// randomized traffic against an age-ordered queue model.
module tb_oldest2_req_ring;

    localparam int SW = 8;
    localparam int PW = 3;

    logic          clk;
    logic          rst;
    logic          flush_i;
    logic          alloc_first_valid_i, alloc_second_valid_i;
    logic          alloc_first_ready_i, alloc_second_ready_i;
    logic          alloc_first_ls_i, alloc_second_ls_i;
    logic          alloc_ready_o;
    logic [PW-1:0] alloc_first_index_o, alloc_second_index_o;
    logic [SW-1:0] wakeup_i;
    logic          first_grant_valid_i, second_grant_valid_i;
    logic [PW-1:0] first_grant_index_i, second_grant_index_i;
    logic [SW-1:0] req_o, req_ls_o;
    logic [PW-1:0] priority_fix_o;
    logic [PW:0]   count_o;
    logic          empty_o;

    oldest2_req_ring #(.SEL_WIDTH(SW), .PRIORITY_WIDTH(PW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush_i              (flush_i),
        .alloc_first_valid_i  (alloc_first_valid_i),
        .alloc_second_valid_i (alloc_second_valid_i),
        .alloc_first_ready_i  (alloc_first_ready_i),
        .alloc_second_ready_i (alloc_second_ready_i),
        .alloc_first_ls_i     (alloc_first_ls_i),
        .alloc_second_ls_i    (alloc_second_ls_i),
        .alloc_ready_o        (alloc_ready_o),
        .alloc_first_index_o  (alloc_first_index_o),
        .alloc_second_index_o (alloc_second_index_o),
        .wakeup_i             (wakeup_i),
        .first_grant_valid_i  (first_grant_valid_i),
        .first_grant_index_i  (first_grant_index_i),
        .second_grant_valid_i (second_grant_valid_i),
        .second_grant_index_i (second_grant_index_i),
        .req_o                (req_o),
        .req_ls_o             (req_ls_o),
        .priority_fix_o       (priority_fix_o),
        .count_o              (count_o),
        .empty_o              (empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit          flush;
        bit          a1v, a2v, a1r, a2r, a1ls, a2ls;
        bit [SW-1:0] wake;
        bit          g1v;
        bit [PW-1:0] g1i;
        bit          g2v;
        bit [PW-1:0] g2i;
    } stim_t;

    typedef struct {
        stim_t       stim;
        bit [SW-1:0] eReq;
        bit [SW-1:0] eLs;
        int          ePrio;
        int          eCount;
        bit          eAready;
        int          eIdx1;
    } vec_t;

    // Model: live entries in age order, oldest first.
    typedef struct {
        int slot;
        bit ready;
        bit ls;
        bit issued;
    } mentry_t;

    mentry_t mq[$];
    int      mhead = 0;
    vec_t    vecs[$];
    int      total = 0;
    int      bad   = 0;

    function automatic stim_t S(bit fl, bit a1v, bit a2v, bit a1r, bit a2r, bit a1ls, bit a2ls,
                                bit [SW-1:0] wk, bit g1v, bit [PW-1:0] g1i, bit g2v, bit [PW-1:0] g2i);
        stim_t s;
        s.flush = fl; s.a1v = a1v; s.a2v = a2v; s.a1r = a1r; s.a2r = a2r;
        s.a1ls = a1ls; s.a2ls = a2ls; s.wake = wk;
        s.g1v = g1v; s.g1i = g1i; s.g2v = g2v; s.g2i = g2i;
        return s;
    endfunction

    function automatic void addVec(stim_t s, bit [SW-1:0] rq, bit [SW-1:0] ls,
                                   int prio, int cnt, bit ar, int idx1);
        vec_t v;
        v.stim = s; v.eReq = rq; v.eLs = ls; v.ePrio = prio;
        v.eCount = cnt; v.eAready = ar; v.eIdx1 = idx1;
        vecs.push_back(v);
    endfunction

    function automatic void modelStep();
        int nret;
        int tailSlot;
        bit canAlloc;
        if (flush_i) begin
            mq.delete();
            mhead = 0;
            return;
        end
        nret = 0;
        if (mq.size() > 0 && mq[0].issued) begin
            nret = 1;
            if (mq.size() > 1 && mq[1].issued) nret = 2;
        end
        tailSlot = (mhead + mq.size()) % SW;
        canAlloc = (SW - mq.size()) >= 2;
        foreach (mq[k]) begin
            if (wakeup_i[mq[k].slot]) mq[k].ready = 1'b1;
            if (first_grant_valid_i && int'(first_grant_index_i) == mq[k].slot) mq[k].issued = 1'b1;
            if (second_grant_valid_i && int'(second_grant_index_i) == mq[k].slot) mq[k].issued = 1'b1;
        end
        for (int k = 0; k < nret; k++) void'(mq.pop_front());
        mhead = (mhead + nret) % SW;
        if (canAlloc && alloc_first_valid_i) begin
            mq.push_back('{tailSlot, alloc_first_ready_i | wakeup_i[tailSlot], alloc_first_ls_i, 1'b0});
            if (alloc_second_valid_i) begin
                int s2;
                s2 = (tailSlot + 1) % SW;
                mq.push_back('{s2, alloc_second_ready_i | wakeup_i[s2], alloc_second_ls_i, 1'b0});
            end
        end
    endfunction

    task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s %s actual=%0h expected=%0h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input bit [SW-1:0] eReq, input bit [SW-1:0] eLs,
                               input int ePrio, input int eCount, input bit eAready, input int eIdx1);
        cmp(name, "req_o",       32'(req_o),                32'(eReq));
        cmp(name, "req_ls_o",    32'(req_ls_o),             32'(eLs));
        cmp(name, "priority",    32'(priority_fix_o),       32'(ePrio));
        cmp(name, "count",       32'(count_o),              32'(eCount));
        cmp(name, "empty",       32'(empty_o),              32'(eCount == 0));
        cmp(name, "alloc_ready", 32'(alloc_ready_o),        32'(eAready));
        cmp(name, "idx1",        32'(alloc_first_index_o),  32'(eIdx1));
        cmp(name, "idx2",        32'(alloc_second_index_o), 32'((eIdx1 + 1) % SW));
    endtask

    task automatic checkModel(input string name);
        bit [SW-1:0] eReq;
        bit [SW-1:0] eLs;
        eReq = '0;
        eLs  = '0;
        foreach (mq[k]) begin
            if (mq[k].ready && !mq[k].issued) eReq[mq[k].slot] = 1'b1;
            if (mq[k].ls && !mq[k].issued)    eLs[mq[k].slot]  = 1'b1;
        end
        checkOutput(name, eReq, eLs, mhead, mq.size(), (SW - mq.size()) >= 2,
                    (mhead + mq.size()) % SW);
    endtask

    task automatic applyStimulus(input stim_t s);
        flush_i              = s.flush;
        alloc_first_valid_i  = s.a1v;
        alloc_second_valid_i = s.a2v;
        alloc_first_ready_i  = s.a1r;
        alloc_second_ready_i = s.a2r;
        alloc_first_ls_i     = s.a1ls;
        alloc_second_ls_i    = s.a2ls;
        wakeup_i             = s.wake;
        first_grant_valid_i  = s.g1v;
        first_grant_index_i  = s.g1i;
        second_grant_valid_i = s.g2v;
        second_grant_index_i = s.g2i;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    function automatic stim_t randomStim();
        stim_t s;
        int cand[$];
        s = '0;
        s.flush = ($urandom_range(0, 49) == 0);
        s.a1v   = ($urandom_range(0, 9) < 6);
        s.a2v   = ($urandom_range(0, 1) == 1);
        s.a1r   = $urandom_range(0, 1);
        s.a2r   = $urandom_range(0, 1);
        s.a1ls  = $urandom_range(0, 1);
        s.a2ls  = $urandom_range(0, 1);
        s.wake  = SW'($urandom & $urandom);
        foreach (mq[k]) if (!mq[k].issued) cand.push_back(mq[k].slot);
        if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
            s.g1v = 1'b1;
            s.g1i = PW'(cand[$urandom_range(0, cand.size() - 1)]);
        end
        if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
            s.g2v = 1'b1;
            s.g2i = PW'(cand[$urandom_range(0, cand.size() - 1)]);
        end
        return s;
    endfunction

    initial begin
        rst = 1'b1;
        applyStimulusIdleInit();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset", 8'h00, 8'h00, 0, 0, 1'b1, 0);

        //        fl a1v a2v a1r a2r ls1 ls2 wake    g1v g1i g2v g2i      req    ls   prio cnt ar idx1
        addVec(S(0, 1, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0), 8'h03, 8'h00, 0, 2, 1, 2);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 1), 8'h00, 8'h00, 0, 2, 1, 2);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 8'h00, 8'h00, 2, 0, 1, 2);
        addVec(S(0, 1, 1, 0, 0, 1, 1, 8'h00, 0, 0, 0, 0), 8'h00, 8'h0C, 2, 2, 1, 4);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h08, 0, 0, 0, 0), 8'h08, 8'h0C, 2, 2, 1, 4);
        addVec(S(0, 1, 1, 1, 0, 0, 0, 8'h24, 0, 0, 0, 0), 8'h3C, 8'h0C, 2, 4, 1, 6);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 2, 1, 3), 8'h30, 8'h00, 2, 4, 1, 6);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 4, 1, 4), 8'h20, 8'h00, 4, 2, 1, 6);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 5, 0, 0), 8'h00, 8'h00, 5, 1, 1, 6);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 8'h00, 8'h00, 6, 0, 1, 6);
        addVec(S(0, 1, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0), 8'hC0, 8'h00, 6, 2, 1, 0);
        addVec(S(0, 1, 1, 1, 1, 0, 1, 8'h00, 0, 0, 0, 0), 8'hC3, 8'h02, 6, 4, 1, 2);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0), 8'hC2, 8'h02, 6, 4, 1, 2);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 8'hC2, 8'h02, 6, 4, 1, 2);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 6, 1, 7), 8'h02, 8'h02, 6, 4, 1, 2);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 8'h02, 8'h02, 0, 2, 1, 2);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 8'h02, 8'h02, 1, 1, 1, 2);
        addVec(S(1, 1, 1, 1, 1, 0, 0, 8'hFF, 1, 1, 0, 0), 8'h00, 8'h00, 0, 0, 1, 0);
        addVec(S(0, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 8'h00, 8'h00, 0, 2, 1, 2);
        addVec(S(0, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 8'h00, 8'h00, 0, 4, 1, 4);
        addVec(S(0, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 8'h00, 8'h00, 0, 6, 1, 6);
        addVec(S(0, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 8'h00, 8'h00, 0, 8, 0, 0);
        addVec(S(0, 1, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0), 8'h00, 8'h00, 0, 8, 0, 0);
        addVec(S(0, 0, 0, 0, 0, 0, 0, 8'h81, 0, 0, 0, 0), 8'h81, 8'h00, 0, 8, 0, 0);
        addVec(S(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0), 8'h00, 8'h00, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stim);
            checkOutput($sformatf("vec%0d", i), vecs[i].eReq, vecs[i].eLs, vecs[i].ePrio,
                        vecs[i].eCount, vecs[i].eAready, vecs[i].eIdx1);
        end

        for (int n = 0; n < 600; n++) begin
            applyStimulus(randomStim());
            checkModel($sformatf("rand%0d", n));
        end

        // Asynchronous reset taking effect between clock edges.
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 8'h00, 8'h00, 0, 0, 1'b1, 0);
        mq.delete();
        mhead = 0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(S(0, 1, 1, 1, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        checkModel("post_reset_alloc");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic applyStimulusIdleInit();
        flush_i              = 1'b0;
        alloc_first_valid_i  = 1'b0;
        alloc_second_valid_i = 1'b0;
        alloc_first_ready_i  = 1'b0;
        alloc_second_ready_i = 1'b0;
        alloc_first_ls_i     = 1'b0;
        alloc_second_ls_i    = 1'b0;
        wakeup_i             = '0;
        first_grant_valid_i  = 1'b0;
        first_grant_index_i  = '0;
        second_grant_valid_i = 1'b0;
        second_grant_index_i = '0;
    endtask

endmodule

// File: doc/oldest2_req_ring.md
Name: oldest2_req_ring

Overview:
- Circular age-ordered entry ring that produces the request vectors and age pointer consumed by the oldest-2 issue arbiter, and applies that arbiter's grants back onto its entries.
- Allocates up to 2 entries per cycle at the tail, tracks ready, load/store and issued state per entry, and retires issued entries from the head in age order.
- Sits between rename/dispatch (writer) and the oldest2 arbiter (reader) in the RCU issue path.

Parameters:
- SEL_WIDTH, 8, number of ring entries; must be a power of 2.
- PRIORITY_WIDTH, 3, pointer/index width; equals log2(SEL_WIDTH).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- flush_i  input  1  synchronous clear of all entries and pointers.
- alloc_first_valid_i  input  1  allocate entry at tail.
- alloc_second_valid_i  input  1  allocate entry at tail+1; legal only together with first.
- alloc_first_ready_i / alloc_second_ready_i  input  1 each  operands ready at allocation.
- alloc_first_ls_i / alloc_second_ls_i  input  1 each  entry is a load/store.
- alloc_ready_o  output  1  at least 2 free slots; no allocation accepted when low.
- alloc_first_index_o / alloc_second_index_o  output  PRIORITY_WIDTH each  tail, tail+1.
- wakeup_i  input  SEL_WIDTH  one-hot-or-multi vector that sets ready bits.
- first_grant_valid_i / first_grant_index_i  input  1 / PRIORITY_WIDTH  arbiter grant 1.
- second_grant_valid_i / second_grant_index_i  input  1 / PRIORITY_WIDTH  arbiter grant 2.
- req_o  output  SEL_WIDTH  valid & ready & !issued per entry.
- req_ls_o  output  SEL_WIDTH  valid & ls & !issued per entry.
- priority_fix_o  output  PRIORITY_WIDTH  head pointer (oldest entry).
- count_o  output  PRIORITY_WIDTH+1  occupied span, tail minus head.
- empty_o  output  1  count_o == 0.

Behaviour:
- Reset (async) and flush (sync): head=tail=0, count=0, all valid/ready/ls/issued bits 0. Outputs then: req_o=0, req_ls_o=0, priority_fix_o=0, count_o=0, empty_o=1, alloc_ready_o=1, alloc indices 0/1.
- All outputs are derived from flops only; no input-to-output combinational path.
- Allocation: accepted only when alloc_ready_o=1 (SEL_WIDTH-count >= 2). Writes valid=1, issued=0, ready=alloc_ready_i|wakeup_i[slot], and ls. Tail advances by 0/1/2 and wraps modulo SEL_WIDTH. second without first is ignored. Allocation while alloc_ready_o=0 is ignored.
- Wakeup: sets ready on valid entries. Setting ready on an already-ready entry or an invalid entry has no effect except through the allocate-same-cycle rule above.
- Grant: sets issued on the indexed entry at the next edge, so req_o/req_ls_o drop 1 cycle after the grant. A grant to an invalid or already-issued entry is ignored and flagged by an assertion. Equal first/second indices apply once.
- Retire: each cycle the head advances over up to 2 leading entries that are valid & issued, using registered state. The entry at head is checked first, then head+1 only if the head entry retires. Retire never passes tail. Retired entries clear valid.
- count_next = count + allocs - retires. Allocation and retire in the same cycle are both applied. The full condition is count==SEL_WIDTH, and empty is count==0, so head==tail is disambiguated by count.
- Holes: entries issued out of order keep valid=1 until the head passes them. Age order is always head→tail.
- flush_i has priority over alloc, grant and wakeup in the same cycle.

Decomposition:
- Shared rcu package holds the SEL_WIDTH/PRIORITY_WIDTH defaults and an entry-state struct {valid, ready, ls, issued}.
- One natural sub-module, ring_ptr_ctrl. It owns head, tail and count, and computes wrap-around, alloc_ready_o and the retire count.
- Entry state array and vector generation stay in the top.

Test Plan:
- Reset, then allocate 2 ready non-ls entries → next cycle req_o=8'b0000_0011, count_o=2, alloc indices 2/3, priority_fix_o=0.
- Grant indices 0 and 1 → next cycle req_o=0; following cycle priority_fix_o=2, count_o=0, empty_o=1.
- Fill the ring in 4 double-allocation cycles → count_o=8, alloc_ready_o=0. A fifth allocation is ignored and the tail stays at 0.
- Head at 6, allocate 4 entries → slots 6,7,0,1, wrap verified. Grant slot 0 first → it stays valid as a hole and head stays at 6. Granting 6 and 7 then retires 6,7,0 in 2 cycles.
- Allocate ls entries at 2 and 3 not ready, then wakeup_i=8'b0000_1000 → req_o bit 3 set, req_ls_o=8'b0000_1100.
- Flush_i asserted mid-stream together with a grant and a double allocation → next cycle all outputs equal their reset values.
